// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan controller: rotates one shared decoder across the digits,
// double-buffers the displayed value per frame, and applies blink / leading-zero blanking.
module seg_scan_ctrl #(
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_SLOTS = 256,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic        load,
    input  logic [3:0]  blink_mask,
    input  logic        en,
    output logic [3:0]  code,
    output logic [3:0]  an,
    output logic        frame_start
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_SLOTS - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    slot_q, slot_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [3:0]    code_q, code_d;
    logic [3:0]    an_q, an_d;
    logic          frame_start_q, frame_start_d;

    logic tick;
    logic frame_wrap;
    logic blank;

    always_comb begin
        tick       = (pcnt_q == P_LAST);
        frame_wrap = tick && (slot_q == 2'd3);

        pcnt_d = tick ? '0 : pcnt_q + PW'(1);
        slot_d = tick ? slot_q + 2'd1 : slot_q;

        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (tick) begin
            if (bcnt_q == B_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end

        // A load landing on the wrap tick bypasses pend so it shows in the frame just starting.
        shadow_d = shadow_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        if (load && frame_wrap) begin
            shadow_d = digits;
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_d   = digits;
            pend_v_d = 1'b1;
        end else if (frame_wrap && pend_v_q) begin
            shadow_d = pend_q;
            pend_v_d = 1'b0;
        end

        blank = (phase_q && blink_mask[slot_q]) ||
                ((LZ_SUPPRESS != 0) && (slot_q == 2'd3) && (shadow_q[15:12] == 4'h0));

        code_d        = shadow_q[{slot_q, 2'b00} +: 4];
        an_d          = (!en || blank) ? 4'b1111 : ~(4'b0001 << slot_q);
        frame_start_d = frame_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q        <= '0;
            slot_q        <= 2'd0;
            bcnt_q        <= '0;
            phase_q       <= 1'b0;
            shadow_q      <= 16'h0000;
            pend_q        <= 16'h0000;
            pend_v_q      <= 1'b0;
            code_q        <= 4'h0;
            an_q          <= 4'b1111;
            frame_start_q <= 1'b0;
        end else begin
            pcnt_q        <= pcnt_d;
            slot_q        <= slot_d;
            bcnt_q        <= bcnt_d;
            phase_q       <= phase_d;
            shadow_q      <= shadow_d;
            pend_q        <= pend_d;
            pend_v_q      <= pend_v_d;
            code_q        <= code_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign code        = code_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the alarm clock's 4-digit 7-segment display. It shares the single hex-to-7-segment decoder between four digits by driving the decoder's 4-bit input and the active-low anode selects in rotation. It also double-buffers the displayed value so a digit change never appears partway through a frame, and provides per-digit blinking for the alarm/time set modes. It also suppresses a leading zero on the leftmost digit.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot (≥2).
- BLINK_SLOTS, 256: slot ticks per blink half-period (≥1).
- LZ_SUPPRESS, 1: 1 = blank digit 3 when its value is 0.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- digits  in  16  display value; [15:12]=digit 3 (leftmost) … [3:0]=digit 0 (rightmost).
- load  in  1  1-cycle strobe; captures digits.
- blink_mask  in  4  bit i set = digit i blinks.
- en  in  1  display enable; 0 = all anodes off.
- code  out  4  digit value to shared decoder input.
- an  out  4  anode selects, active-low, at most one low.
- frame_start  out  1  1-cycle pulse when slot wraps 3→0.

## Operation
- Prescaler pcnt counts 0..SCAN_DIV-1 and wraps. tick = (pcnt == SCAN_DIV-1).
- Slot register slot[1:0] increments on tick, in the order 0→1→2→3→0. The wrap 3→0 is the frame boundary.
- Buffering:
  - load copies digits into pend and sets pend_v. Repeated loads within one frame: the last one wins.
  - On the frame boundary, if pend_v is set, shadow ← pend and pend_v is cleared.
  - If load coincides with the frame-boundary tick, digits goes directly to shadow and pend_v is cleared.
- Blink:
  - bcnt counts ticks 0..BLINK_SLOTS-1. phase toggles when bcnt wraps.
  - When phase = 1, any digit whose blink_mask bit is set is blanked.
  - blink_mask is sampled live, not buffered.
- Leading zero: if LZ_SUPPRESS = 1 and shadow[15:12] == 0, digit 3 is blanked. Digits 0–2 are never zero-suppressed.
- Output registers, updated every clk:
  - code ← shadow nibble selected by slot. code is driven even when the digit is blanked.
  - an ← all ones when en = 0 or the current digit is blanked; otherwise ~(1 << slot).
- en = 0 does not stop pcnt, slot, bcnt or buffering.
- Reset, asynchronous while rst_n = 0:
  - pcnt = 0, slot = 0, bcnt = 0, phase = 0
  - shadow = 0, pend = 0, pend_v = 0
  - code = 4'h0, an = 4'b1111, frame_start = 0
- Reset applied mid-slot or mid-frame discards any pending load.

## Timing
- Slot period is SCAN_DIV clks. Frame is 4·SCAN_DIV clks. Blink half-period is BLINK_SLOTS·SCAN_DIV clks.
- code and an lag slot by 1 clk: they are registered from the current slot value.
- frame_start is high for exactly the 1 clk in which slot = 0 follows a 3→0 wrap. It does not fire out of reset.
- Load-to-display latency: from load to the next frame boundary, plus 1 clk. Worst case is 4·SCAN_DIV + 1 clks.
- After rst_n deasserts with en = 1: an = 4'b1110 and code = 4'h0 on the first clk edge.
- en change takes effect on an at the next clk edge.
- With LZ_SUPPRESS = 1, blinking digit 3 while shadow[15:12] = 0 leaves it blanked continuously (OR of the two blanking conditions).

## Test plan
Unless noted, SCAN_DIV = 4 and BLINK_SLOTS = 2.

- Scan order: after reset with en = 1, load 16'h1234, then wait one frame boundary. Required: an cycles 1110/1101/1011/0111, each for 4 clks, with code 4/3/2/1. frame_start pulses once every 16 clks.
- Tear-free update: shadow = 16'h1234; in slot 1, load 16'h5678, then load 16'h9ABC two clks later. Required: slots 2 and 3 still show 2 and 1. The next frame shows C, B, A, 9; 5678 is never displayed. Also load 16'h4321 exactly on the frame-boundary tick: that frame shows 1, 2, 3, 4.
- Leading zero: load 16'h0930. Required: an stays 1111 during slot 3. Slot 0 shows code 0 with an = 1110. With LZ_SUPPRESS = 0, slot 3 shows an = 0111, code 0.
- Blink: load 16'h1234, set blink_mask = 4'b0011. Required: digits 0 and 1 are dark (an = 1111 in their slots) on alternate 2-slot windows. Digits 2 and 3 are never dark. blink_mask = 0 stops blanking in the next slot.
- Enable and reset: en = 0 in mid-slot gives an = 1111 from the next clk, and slot keeps advancing. With en = 1, an resumes with no phase jump. Asserting rst_n = 0 mid-slot with a pending load gives an = 1111 and code = 0 immediately. After release, the display shows 0000, and the pending load is lost.
